// File: rtl/tug_of_war_ctrl_pkg.sv
// Purpose : shared types for the Tug of War game controller (FSM states, winner codes).
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package tow_pkg;

   typedef enum logic [1:0] {
      PLAY = 2'd0,
      SHOW = 2'd1,
      OVER = 2'd2
   } state_t;

   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_L    = 2'b10;
   localparam logic [1:0] WIN_R    = 2'b01;

endpackage

// File: rtl/tug_of_war_ctrl_if.sv
// Purpose : bundle of press inputs and game-state outputs of the Tug of War controller.
// Latency : n/a (wires only).
// Backpressure: none; presses are single-cycle pulses and are never stalled.
// Ports   : leftpress/rightpress (press pulses), led (one-hot rope or zero),
//           winner, score_l, score_r, match_over.
interface tug_of_war_ctrl_if #(
   parameter int NUM_LEDS = 9,
   parameter int SCORE_W  = 3
);
   logic                leftpress;
   logic                rightpress;
   logic [NUM_LEDS-1:0] led;
   logic [1:0]          winner;
   logic [SCORE_W-1:0]  score_l;
   logic [SCORE_W-1:0]  score_r;
   logic                match_over;

   // master drives the presses, slave is the controller
   modport master (
      output leftpress, rightpress,
      input  led, winner, score_l, score_r, match_over
   );

   modport slave (
      input  leftpress, rightpress,
      output led, winner, score_l, score_r, match_over
   );
endinterface

// File: rtl/tug_of_war_ctrl_hold_timer.sv
// Purpose : loadable down-counter that times the winner display hold.
// Latency : load/decrement visible after the next clk edge; zero is decoded from the count.
// Backpressure: none; en simply pauses the count, and it stops by itself at zero.
// Ports   : clk, reset (sync, active-high), load, load_val, en, zero.
module hold_timer #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic         zero
);

   logic [W-1:0] count;

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/tug_of_war_ctrl.sv
// Purpose : Tug of War game FSM: moves the rope light, scores rounds, holds the win, ends the match.
// Latency : a press sampled at edge n is reflected on every output after edge n (all outputs registered).
// Backpressure: none; presses during the win hold, in the hold-exit cycle, or after the match are dropped.
// Ports   : clk, reset (sync, active-high), bus (slave modport: leftpress, rightpress in;
//           led, winner, score_l, score_r, match_over out).
module tug_of_war_ctrl
   import tow_pkg::*;
#(
   parameter int NUM_LEDS     = 9,
   parameter int SCORE_W      = 3,
   parameter int MATCH_POINTS = 3,
   parameter int HOLD_CYCLES  = 4
) (
   input  logic              clk,
   input  logic              reset,
   tug_of_war_ctrl_if.slave  bus
);

   localparam int PW = $clog2(NUM_LEDS);
   localparam int TW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

   localparam logic [PW-1:0]      CENTER = PW'((NUM_LEDS - 1) / 2);
   localparam logic [PW-1:0]      MAXPOS = PW'(NUM_LEDS - 1);
   localparam logic [SCORE_W-1:0] MP     = SCORE_W'(MATCH_POINTS);
   localparam logic [TW-1:0]      HOLD_LD = TW'(HOLD_CYCLES - 1);

   state_t              state;
   logic [PW-1:0]       pos;
   logic [NUM_LEDS-1:0] led_q;
   logic [1:0]          winner_q;
   logic [SCORE_W-1:0]  score_l_q;
   logic [SCORE_W-1:0]  score_r_q;
   logic                match_over_q;

   logic                move_l;
   logic                move_r;
   logic                win_l;
   logic                win_r;
   logic [SCORE_W-1:0]  score_l_inc;
   logic [SCORE_W-1:0]  score_r_inc;
   logic                timer_load;
   logic                timer_en;
   logic                timer_zero;

   function automatic logic [NUM_LEDS-1:0] onehot(input logic [PW-1:0] idx);
      onehot = {{(NUM_LEDS-1){1'b0}}, 1'b1} << idx;
   endfunction

   // Simultaneous presses cancel, so only a lone press counts as a move.
   always_comb begin
      move_l      = bus.leftpress & ~bus.rightpress;
      move_r      = bus.rightpress & ~bus.leftpress;
      win_l       = (state == PLAY) && move_l && (pos == MAXPOS);
      win_r       = (state == PLAY) && move_r && (pos == '0);
      score_l_inc = score_l_q + 1'b1;
      score_r_inc = score_r_q + 1'b1;
      // A match-winning round goes straight to OVER and never needs the hold.
      timer_load  = (win_l && (score_l_inc != MP)) || (win_r && (score_r_inc != MP));
      timer_en    = (state == SHOW);
   end

   hold_timer #(.W(TW)) u_hold_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (timer_load),
      .load_val (HOLD_LD),
      .en       (timer_en),
      .zero     (timer_zero)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= PLAY;
         pos          <= CENTER;
         led_q        <= onehot(CENTER);
         winner_q     <= WIN_NONE;
         score_l_q    <= '0;
         score_r_q    <= '0;
         match_over_q <= 1'b0;
      end else begin
         case (state)
            PLAY: begin
               if (win_l) begin
                  score_l_q <= score_l_inc;
                  winner_q  <= WIN_L;
                  led_q     <= '0;
                  if (score_l_inc == MP) begin
                     state        <= OVER;
                     match_over_q <= 1'b1;
                  end else begin
                     state <= SHOW;
                  end
               end else if (win_r) begin
                  score_r_q <= score_r_inc;
                  winner_q  <= WIN_R;
                  led_q     <= '0;
                  if (score_r_inc == MP) begin
                     state        <= OVER;
                     match_over_q <= 1'b1;
                  end else begin
                     state <= SHOW;
                  end
               end else if (move_l) begin
                  pos   <= pos + 1'b1;
                  led_q <= onehot(pos + 1'b1);
               end else if (move_r) begin
                  pos   <= pos - 1'b1;
                  led_q <= onehot(pos - 1'b1);
               end
            end
            SHOW: begin
               // Exit when the hold has counted down; any press this cycle is dropped.
               if (timer_zero) begin
                  state    <= PLAY;
                  pos      <= CENTER;
                  led_q    <= onehot(CENTER);
                  winner_q <= WIN_NONE;
               end
            end
            OVER: begin
               // Frozen until reset.
            end
            default: begin
               state <= PLAY;
               pos   <= CENTER;
               led_q <= onehot(CENTER);
            end
         endcase
      end
   end

   assign bus.led        = led_q;
   assign bus.winner     = winner_q;
   assign bus.score_l    = score_l_q;
   assign bus.score_r    = score_r_q;
   assign bus.match_over = match_over_q;

endmodule

// File: tb/tb_tug_of_war_ctrl.sv
// Purpose : self-checking bench for tug_of_war_ctrl against a behavioural game model.
// Latency : each step drives inputs at negedge, advances one posedge, checks #1 later.
// Backpressure: n/a.
module tb_tug_of_war_ctrl;

   localparam int N    = 9;
   localparam int SW   = 3;
   localparam int MPTS = 3;
   localparam int HOLD = 4;
   localparam int CEN  = (N - 1) / 2;

   logic clk;
   logic reset;

   tug_of_war_ctrl_if #(.NUM_LEDS(N), .SCORE_W(SW)) bus ();

   tug_of_war_ctrl #(
      .NUM_LEDS(N), .SCORE_W(SW), .MATCH_POINTS(MPTS), .HOLD_CYCLES(HOLD)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Game model: rope index, scores, remaining display-hold cycles, match-over flag.
   int         m_pos  = CEN;
   int         m_sl   = 0;
   int         m_sr   = 0;
   int         m_hold = 0;
   bit         m_over = 1'b0;
   logic [1:0] m_win  = 2'b00;

   task automatic model(input bit l, input bit r, input bit rst);
      if (rst) begin
         m_pos = CEN; m_sl = 0; m_sr = 0; m_hold = 0; m_over = 1'b0; m_win = 2'b00;
      end else if (m_over) begin
         // frozen
      end else if (m_hold > 0) begin
         m_hold--;
         if (m_hold == 0) begin
            m_pos = CEN;
            m_win = 2'b00;
         end
      end else if (l && !r) begin
         if (m_pos == N - 1) begin
            m_sl++;
            m_win = 2'b10;
            if (m_sl == MPTS) m_over = 1'b1;
            else m_hold = HOLD;
         end else begin
            m_pos++;
         end
      end else if (r && !l) begin
         if (m_pos == 0) begin
            m_sr++;
            m_win = 2'b01;
            if (m_sr == MPTS) m_over = 1'b1;
            else m_hold = HOLD;
         end else begin
            m_pos--;
         end
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      logic [N-1:0] e_led;
      e_led = (m_over || m_hold > 0) ? '0 : (N'(1) << m_pos);
      check("led",        32'(bus.led),        32'(e_led));
      check("winner",     32'(bus.winner),     32'(m_win));
      check("score_l",    32'(bus.score_l),    32'(m_sl));
      check("score_r",    32'(bus.score_r),    32'(m_sr));
      check("match_over", 32'(bus.match_over), 32'(m_over));
      check("led_onehot0", 32'($onehot0(bus.led)), 32'(1));
   endtask

   task automatic step(input bit l, input bit r, input bit rst);
      @(negedge clk);
      bus.leftpress  = l;
      bus.rightpress = r;
      reset          = rst;
      @(posedge clk);
      model(l, r, rst);
      #1;
      check_all();
   endtask

   initial begin
      bus.leftpress  = 1'b0;
      bus.rightpress = 1'b0;
      reset          = 1'b1;

      // Reset state
      step(0, 0, 1);
      check("rst_led", 32'(bus.led), 32'h010);

      // Scenario 1: three left presses walk the rope left
      step(1, 0, 0);
      check("s1_led1", 32'(bus.led), 32'h020);
      step(1, 0, 0);
      check("s1_led2", 32'(bus.led), 32'h040);
      step(1, 0, 0);
      check("s1_led3", 32'(bus.led), 32'h080);

      // Scenario 2: simultaneous presses at centre and at index 8 cancel
      step(0, 0, 1);
      step(1, 1, 0);
      check("s2_centre", 32'(bus.led), 32'h010);
      for (int i = 0; i < 4; i++) step(1, 0, 0);
      step(1, 1, 0);
      check("s2_edge", 32'(bus.led), 32'h100);
      check("s2_score", 32'(bus.score_l), 32'd0);

      // Scenario 3: left wins a round, presses during hold ignored
      step(1, 0, 0);
      check("s3_win_led", 32'(bus.led), 32'h000);
      check("s3_winner",  32'(bus.winner), 32'h2);
      check("s3_score_l", 32'(bus.score_l), 32'd1);
      step(1, 0, 0);
      step(0, 1, 0);
      step(1, 1, 0);
      step(1, 0, 0);   // hold-exit cycle: press dropped
      check("s3_back_led", 32'(bus.led), 32'h010);
      check("s3_back_win", 32'(bus.winner), 32'h0);

      // Scenario 4: right wins three rounds and the match
      step(0, 0, 1);
      for (int rnd = 0; rnd < MPTS; rnd++) begin
         for (int i = 0; i < 5; i++) step(0, 1, 0);
         if (rnd < MPTS - 1) for (int i = 0; i < HOLD; i++) step(0, 0, 0);
      end
      check("s4_score_r", 32'(bus.score_r), 32'd3);
      check("s4_over",    32'(bus.match_over), 32'd1);
      check("s4_winner",  32'(bus.winner), 32'h1);
      for (int i = 0; i < 6; i++) step(i[0], !i[0], 0);
      step(1, 1, 0);
      check("s4_frozen", 32'(bus.score_r), 32'd3);

      // Scenario 5: reset in the second SHOW cycle
      step(0, 0, 1);
      for (int i = 0; i < 5; i++) step(1, 0, 0);
      step(0, 0, 0);
      step(0, 0, 1);
      check("s5_led",    32'(bus.led), 32'h010);
      check("s5_score",  32'(bus.score_l), 32'd0);
      check("s5_winner", 32'(bus.winner), 32'h0);
      check("s5_over",   32'(bus.match_over), 32'd0);

      // Scenario 6: alternating presses oscillate centre <-> centre+1
      for (int i = 0; i < 20; i++) begin
         step(!i[0], i[0], 0);
         check("s6_osc", 32'(bus.led), i[0] ? 32'h010 : 32'h020);
      end

      // Randomized play, biased toward left so rounds and matches complete
      step(0, 0, 1);
      for (int i = 0; i < 1500; i++) begin
         bit l, r, rs;
         l  = ($urandom_range(0, 99) < 55);
         r  = ($urandom_range(0, 99) < 30);
         rs = ($urandom_range(0, 199) == 0);
         step(l, r, rs);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
